fcml_frame_ctrl: RTL and testbench

Frame controller between the 48-bit SPI receiver and the three-phase FCML modulator. It detects frame completion from `spi_cs`, validates each received frame (sync byte, address, optional checksum) and stages per-phase duty and enable writes in shadow registers. Staged values commit atomically on the next carrier-period boundary. A watchdog disables PWM when valid frames stop arriving.

---
 rtl/fcml_frame_ctrl.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_fcml_frame_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fcml_frame_ctrl.sv
// fcml_frame_ctrl
// Frame controller between the 48-bit SPI receiver and the three-phase FCML
// modulator.
//
// Frame completion comes from the rising edge of the synchronized spi_cs.
// Each frame is checked for the sync byte and a legal address. Valid writes go
// into shadow registers. The shadow registers are committed atomically on the
// next carrier_sync. A watchdog clears pwm_en when valid frames stop arriving.
//
// Optional feature:
//   FRAME_CHK_EN - when defined, the chk byte [7:0] must equal the XOR of
//                  bytes [47:40], [39:32], [31:24], [23:16] and [15:8].
//                  When undefined, chk is ignored.
//
// Frame layout: [47:40] sync, [39:36] addr, [35:24] reserved,
//               [23:8] data, [7:0] chk.
// Address map:  0/1/2 duty A/B/C (clamped to DUTY_MAX), 3 enable (data[0]).

module fcml_frame_ctrl #(
  parameter logic [31:0] WD_CYCLES = 32'd10_000_000,
  parameter logic [15:0] DUTY_MAX  = 16'd1000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_cs,
  input  logic [47:0] spi_rdata,
  input  logic        carrier_sync,
  output logic [15:0] duty_a,
  output logic [15:0] duty_b,
  output logic [15:0] duty_c,
  output logic        pwm_en,
  output logic        cfg_update,
  output logic [7:0]  frame_err_cnt,
  output logic        wd_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_CHECK,
    S_PEND,
    S_COMMIT
  } state_t;

  state_t state, state_next;

  // spi_cs synchronizer and edge-detect delay stage
  logic cs_meta, cs_sync, cs_dly;
  logic frame_edge;
  logic edge_pend;
  logic edge_seen;
  logic take_edge;
  logic do_commit;

  // Captured frame and its decoded fields
  logic [47:0] frame_q;
  logic [7:0]  frame_sync;
  logic [3:0]  frame_addr;
  logic [15:0] frame_data;
  logic [15:0] data_clamped;
  logic        sync_ok;
  logic        addr_ok;
  logic        chk_ok;
  logic        frame_ok;
  logic        frame_write;
  logic        frame_reject;
  logic        unused_frame_bits;

  // Shadow registers staged by valid frames
  logic [15:0] shadow_a, shadow_b, shadow_c;
  logic        shadow_en;
  logic        pending;

  // Watchdog
  logic [31:0] wd_cnt;
  logic        wd_trip;

  // Two-flop synchronizer for the asynchronous chip select, plus a third
  // stage to find its rising edge.
  // NOTE: Sequential state uses non-blocking (<=) assignments so that every
  // flop samples the pre-edge value of its source. With blocking assignments
  // the three stages would collapse into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta <= 1'b0;
      cs_sync <= 1'b0;
      cs_dly  <= 1'b0;
    end else begin
      cs_meta <= spi_cs;
      cs_sync <= cs_meta;
      cs_dly  <= cs_sync;
    end
  end

  assign frame_edge = cs_sync & ~cs_dly;
  assign edge_seen  = frame_edge | edge_pend;

  // Remember frame-end edges that arrive while the FSM cannot service them.
  // A fresh edge that coincides with consuming an older one is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_pend <= 1'b0;
    end else if (take_edge) begin
      edge_pend <= frame_edge & edge_pend;
    end else begin
      edge_pend <= edge_seen;
    end
  end

  // Decode and validate the captured frame
  assign frame_sync = frame_q[47:40];
  assign frame_addr = frame_q[39:36];
  assign frame_data = frame_q[23:8];

  assign sync_ok      = (frame_sync == SYNC_BYTE);
  assign addr_ok      = (frame_addr <= 4'd3);
  assign data_clamped = (frame_data > DUTY_MAX) ? DUTY_MAX : frame_data;

`ifdef FRAME_CHK_EN
  assign chk_ok = (frame_q[7:0] == (frame_q[47:40] ^ frame_q[39:32] ^
                                    frame_q[31:24] ^ frame_q[23:16] ^
                                    frame_q[15:8]));
`else
  assign chk_ok = 1'b1;
`endif

  // Reserved bits are never used, and chk is used only when checking is built in.
  assign unused_frame_bits = ^{frame_q[35:24], frame_q[7:0]};

  assign frame_ok     = sync_ok & addr_ok & chk_ok;
  assign frame_write  = (state == S_CHECK) &  frame_ok;
  assign frame_reject = (state == S_CHECK) & ~frame_ok;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state and control strobes. In PEND, carrier_sync takes
  // priority over a waiting frame edge.
  // NOTE: Every signal assigned in an always_comb gets a default before the
  // case statement. Without the default, a path that leaves the signal
  // unassigned infers a latch.
  always_comb begin
    state_next = state;
    take_edge  = 1'b0;
    do_commit  = 1'b0;
    case (state)
      S_IDLE: begin
        if (edge_seen) begin
          state_next = S_CAPTURE;
          take_edge  = 1'b1;
        end
      end
      S_CAPTURE: begin
        state_next = S_CHECK;
      end
      S_CHECK: begin
        if (frame_ok || pending) begin
          state_next = S_PEND;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_PEND: begin
        if (carrier_sync) begin
          state_next = S_COMMIT;
          do_commit  = 1'b1;
        end else if (edge_seen) begin
          state_next = S_CAPTURE;
          take_edge  = 1'b1;
        end
      end
      S_COMMIT: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Capture the receiver's frame word. By this time the word has been stable
  // for at least three cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (state == S_CAPTURE) begin
      frame_q <= spi_rdata;
    end
  end

  // Shadow registers. Writes from several frames accumulate until a commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_a  <= '0;
      shadow_b  <= '0;
      shadow_c  <= '0;
      shadow_en <= 1'b0;
    end else begin
      if (wd_trip) begin
        shadow_en <= 1'b0;
      end
      if (frame_write) begin
        case (frame_addr[1:0])
          2'd0:    shadow_a  <= data_clamped;
          2'd1:    shadow_b  <= data_clamped;
          2'd2:    shadow_c  <= data_clamped;
          default: shadow_en <= frame_data[0];
        endcase
      end
    end
  end

  // pending is set by any valid write and cleared by the commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (frame_write) begin
      pending <= 1'b1;
    end else if (state == S_COMMIT) begin
      pending <= 1'b0;
    end
  end

  // Count rejected frames, saturating at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_cnt <= '0;
    end else if (frame_reject && (frame_err_cnt != 8'hFF)) begin
      frame_err_cnt <= frame_err_cnt + 8'd1;
    end
  end

  // Watchdog: counts only while enabled and restarts on every valid frame
  assign wd_trip = pwm_en & (wd_cnt == (WD_CYCLES - 32'd1));

  // Watchdog counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (!pwm_en || wd_trip || frame_write) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end

  // Committed outputs. They change on the edge that sees carrier_sync in PEND,
  // so the new values and cfg_update appear together during COMMIT. The only
  // other change is the watchdog clearing pwm_en. A trip never changes the
  // duty values and never pulses cfg_update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_a     <= '0;
      duty_b     <= '0;
      duty_c     <= '0;
      pwm_en     <= 1'b0;
      cfg_update <= 1'b0;
      wd_timeout <= 1'b0;
    end else begin
      cfg_update <= do_commit;
      if (do_commit) begin
        duty_a <= shadow_a;
        duty_b <= shadow_b;
        duty_c <= shadow_c;
        pwm_en <= shadow_en;
        if (shadow_en) begin
          wd_timeout <= 1'b0;
        end
      end else if (wd_trip) begin
        pwm_en     <= 1'b0;
        wd_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fcml_frame_ctrl.sv
// Directed testbench for fcml_frame_ctrl. The watchdog is shortened to 64
// cycles so that a trip can be reached quickly.
// Inputs change 1 time unit after posedge. Outputs are sampled at the same point.

module tb_fcml_frame_ctrl;

  localparam logic [31:0] WD = 32'd64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_cs;
  logic [47:0] spi_rdata;
  logic        carrier_sync;
  logic [15:0] duty_a, duty_b, duty_c;
  logic        pwm_en;
  logic        cfg_update;
  logic [7:0]  frame_err_cnt;
  logic        wd_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  fcml_frame_ctrl #(
    .WD_CYCLES (WD),
    .DUTY_MAX  (16'd1000),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi_cs        (spi_cs),
    .spi_rdata     (spi_rdata),
    .carrier_sync  (carrier_sync),
    .duty_a        (duty_a),
    .duty_b        (duty_b),
    .duty_c        (duty_c),
    .pwm_en        (pwm_en),
    .cfg_update    (cfg_update),
    .frame_err_cnt (frame_err_cnt),
    .wd_timeout    (wd_timeout)
  );

  always #5 clk = ~clk;

  // Builds a frame with reserved bits set to zero and a correct chk byte
  function automatic logic [47:0] mk_frame(input logic [7:0] sb, input logic [3:0] addr,
                                           input logic [15:0] data);
    logic [7:0] c;
    c = sb ^ {addr, 4'h0} ^ 8'h00 ^ data[15:8] ^ data[7:0];
    return {sb, addr, 12'h000, data, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word, raise spi_cs, hold it long enough to be captured, then drop it
  task automatic send_frame(input logic [47:0] word);
    spi_cs    = 1'b0;
    spi_rdata = word;
    repeat (2) tick();
    spi_cs = 1'b1;
    repeat (8) tick();
    spi_cs = 1'b0;
    repeat (3) tick();
  endtask

  // One-cycle carrier_sync. Returns just after the edge that sampled it.
  task automatic pulse_sync();
    carrier_sync = 1'b1;
    tick();
    carrier_sync = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; spi_cs = 1'b0; spi_rdata = '0; carrier_sync = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (duty_a !== 16'd0) begin n_fail++; $display("FAIL reset_duty_a got %0d want 0", duty_a); end
    n_checks++; if (duty_b !== 16'd0) begin n_fail++; $display("FAIL reset_duty_b got %0d want 0", duty_b); end
    n_checks++; if (duty_c !== 16'd0) begin n_fail++; $display("FAIL reset_duty_c got %0d want 0", duty_c); end
    n_checks++; if (pwm_en !== 1'b0) begin n_fail++; $display("FAIL reset_pwm_en got %b want 0", pwm_en); end
    n_checks++; if (frame_err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", frame_err_cnt); end
    n_checks++; if (wd_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_wd_timeout got %b want 0", wd_timeout); end
    // A carrier_sync with nothing pending has no effect
    pulse_sync();
    n_checks++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL idle_sync_cfg got %b want 0", cfg_update); end
  endtask

  task automatic test_duty_a();
    send_frame(48'hA5_00_00_01F4_50);
    n_checks++; if (duty_a !== 16'd0) begin n_fail++; $display("FAIL duty_a_before_commit got %0d want 0", duty_a); end
    pulse_sync();
    n_checks++; if (cfg_update !== 1'b1) begin n_fail++; $display("FAIL duty_a_cfg got %b want 1", cfg_update); end
    n_checks++; if (duty_a !== 16'd500) begin n_fail++; $display("FAIL duty_a got %0d want 500", duty_a); end
    n_checks++; if (duty_b !== 16'd0) begin n_fail++; $display("FAIL duty_a_b got %0d want 0", duty_b); end
    n_checks++; if (duty_c !== 16'd0) begin n_fail++; $display("FAIL duty_a_c got %0d want 0", duty_c); end
    tick();
    n_checks++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL duty_a_cfg_width got %b want 0", cfg_update); end
    n_checks++; if (duty_a !== 16'd500) begin n_fail++; $display("FAIL duty_a_hold got %0d want 500", duty_a); end
  endtask

  task automatic test_clamp();
    send_frame(mk_frame(8'hA5, 4'd2, 16'd2000));
    n_checks++; if (duty_c !== 16'd0) begin n_fail++; $display("FAIL clamp_before_commit got %0d want 0", duty_c); end
    pulse_sync();
    n_checks++; if (duty_c !== 16'd1000) begin n_fail++; $display("FAIL clamp_duty_c got %0d want 1000", duty_c); end
    n_checks++; if (duty_a !== 16'd500) begin n_fail++; $display("FAIL clamp_duty_a got %0d want 500", duty_a); end
    tick();
  endtask

  task automatic test_bad_frames();
    send_frame(mk_frame(8'h5A, 4'd0, 16'd123));
    n_checks++; if (frame_err_cnt !== 8'd1) begin n_fail++; $display("FAIL bad_sync_cnt got %0d want 1", frame_err_cnt); end
    pulse_sync();
    n_checks++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL bad_sync_cfg got %b want 0", cfg_update); end
    n_checks++; if (duty_a !== 16'd500) begin n_fail++; $display("FAIL bad_sync_duty_a got %0d want 500", duty_a); end
    send_frame(mk_frame(8'hA5, 4'd4, 16'd1));
    n_checks++; if (frame_err_cnt !== 8'd2) begin n_fail++; $display("FAIL bad_addr_cnt got %0d want 2", frame_err_cnt); end
`ifdef FRAME_CHK_EN
    send_frame(mk_frame(8'hA5, 4'd0, 16'd77) ^ 48'h1);
    n_checks++; if (frame_err_cnt !== 8'd3) begin n_fail++; $display("FAIL bad_chk_cnt got %0d want 3", frame_err_cnt); end
    pulse_sync();
    n_checks++; if (duty_a !== 16'd500) begin n_fail++; $display("FAIL bad_chk_duty_a got %0d want 500", duty_a); end
`endif
    for (int i = 0; i < 258; i++) send_frame(mk_frame(8'h5A, 4'd1, 16'd9));
    n_checks++; if (frame_err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_saturate got %0d want 255", frame_err_cnt); end
    n_checks++; if (duty_b !== 16'd0) begin n_fail++; $display("FAIL bad_duty_b got %0d want 0", duty_b); end
  endtask

  // Two frames accumulate in the shadow registers and commit with a single
  // cfg_update. Ends one cycle after the commit edge.
  task automatic test_accumulate();
    send_frame(mk_frame(8'hA5, 4'd1, 16'd300));
    send_frame(48'hA5_30_00_0001_94);
    n_checks++; if (pwm_en !== 1'b0) begin n_fail++; $display("FAIL acc_en_before got %b want 0", pwm_en); end
    n_checks++; if (duty_b !== 16'd0) begin n_fail++; $display("FAIL acc_b_before got %0d want 0", duty_b); end
    pulse_sync();
    n_checks++; if (cfg_update !== 1'b1) begin n_fail++; $display("FAIL acc_cfg got %b want 1", cfg_update); end
    n_checks++; if (duty_b !== 16'd300) begin n_fail++; $display("FAIL acc_duty_b got %0d want 300", duty_b); end
    n_checks++; if (pwm_en !== 1'b1) begin n_fail++; $display("FAIL acc_pwm_en got %b want 1", pwm_en); end
    tick();
    n_checks++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL acc_cfg_width got %b want 0", cfg_update); end
  endtask

  // Must directly follow test_accumulate. pwm_en rose at commit edge E, the
  // bench is now at E+1, and the trip is due at edge E+WD.
  task automatic test_watchdog();
    repeat (WD - 2) tick();
    n_checks++; if (pwm_en !== 1'b1) begin n_fail++; $display("FAIL wd_early_pwm_en got %b want 1", pwm_en); end
    n_checks++; if (wd_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_early_flag got %b want 0", wd_timeout); end
    tick();
    n_checks++; if (pwm_en !== 1'b0) begin n_fail++; $display("FAIL wd_pwm_en got %b want 0", pwm_en); end
    n_checks++; if (wd_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_flag got %b want 1", wd_timeout); end
    n_checks++; if (duty_b !== 16'd300) begin n_fail++; $display("FAIL wd_duty_b_hold got %0d want 300", duty_b); end
    n_checks++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL wd_cfg got %b want 0", cfg_update); end
    repeat (5) tick();
    n_checks++; if (wd_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_sticky got %b want 1", wd_timeout); end
  endtask

  task automatic test_reenable();
    send_frame(mk_frame(8'hA5, 4'd3, 16'd1));
    pulse_sync();
    n_checks++; if (pwm_en !== 1'b1) begin n_fail++; $display("FAIL reen_pwm_en got %b want 1", pwm_en); end
    n_checks++; if (wd_timeout !== 1'b0) begin n_fail++; $display("FAIL reen_flag got %b want 0", wd_timeout); end
    n_checks++; if (cfg_update !== 1'b1) begin n_fail++; $display("FAIL reen_cfg got %b want 1", cfg_update); end
    tick();
  endtask

  task automatic test_reset_in_pend();
    send_frame(mk_frame(8'hA5, 4'd0, 16'd7));
    rst_n = 1'b0;
    #1;
    n_checks++; if (duty_a !== 16'd0) begin n_fail++; $display("FAIL rstp_duty_a got %0d want 0", duty_a); end
    n_checks++; if (duty_b !== 16'd0) begin n_fail++; $display("FAIL rstp_duty_b got %0d want 0", duty_b); end
    n_checks++; if (duty_c !== 16'd0) begin n_fail++; $display("FAIL rstp_duty_c got %0d want 0", duty_c); end
    n_checks++; if (pwm_en !== 1'b0) begin n_fail++; $display("FAIL rstp_pwm_en got %b want 0", pwm_en); end
    n_checks++; if (frame_err_cnt !== 8'd0) begin n_fail++; $display("FAIL rstp_err got %0d want 0", frame_err_cnt); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    pulse_sync();
    n_checks++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL rstp_cfg got %b want 0", cfg_update); end
    tick();
    n_checks++; if (duty_a !== 16'd0) begin n_fail++; $display("FAIL rstp_discard got %0d want 0", duty_a); end
  endtask

  initial begin
    test_reset();
    test_duty_a();
    test_clamp();
    test_bad_frames();
    test_accumulate();
    test_watchdog();
    test_reenable();
    test_reset_in_pend();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
